// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default geometry, named stage indices for the
// classic 5-stage instance, and a helper to locate a stage in flat vectors.
package pipe_pkg;

  localparam int DEF_NSTAGE    = 5;
  localparam int DEF_PAYLOAD_W = 32;

  // Stage indices for the 5-stage instance; stage 0 is the youngest.
  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // Bit offset of stage idx inside a flat vector of w-bit payloads.
  function automatic int stage_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: valid bit plus payload with kill > load > hold.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_kill,
  input  logic                 i_allow,
  input  logic                 i_go_prev,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_payload
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_payload;

  // Valid/payload update; payload only moves on a real handoff so bubbles keep it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_allow) begin
      r_valid <= i_go_prev;
      if (i_go_prev) begin
        r_payload <= i_payload;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/pipe_handshake_chain.sv
// N-stage valid/allow_in/ready_go pipeline controller with flush and cancel.
// The allow_in and kill chains are combinational; state lives in pipe_stage_reg.
module pipe_handshake_chain
  import pipe_pkg::*;
#(
  parameter int NSTAGE    = DEF_NSTAGE,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_allow,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic [NSTAGE-1:0]             stage_ready_go,
  input  logic [NSTAGE-1:0]             flush_req,
  input  logic                          cancel_all,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [NSTAGE-1:0]             stage_valid,
  output logic [NSTAGE*PAYLOAD_W-1:0]   stage_payload,
  output logic [NSTAGE-1:0]             stage_allow_in,
  output logic [$clog2(NSTAGE+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]    w_valid;
  logic [PAYLOAD_W-1:0] w_payload [NSTAGE];
  logic [PAYLOAD_W-1:0] w_src     [NSTAGE];
  logic [NSTAGE:0]      w_allow;
  logic [NSTAGE-1:0]    w_kill;
  logic [NSTAGE-1:0]    w_go;
  logic [NSTAGE-1:0]    w_go_prev;
  logic                 w_go_in;
  logic [OCC_W-1:0]     w_occ;

  // allow_in chain from the consumer back to the producer.
  always_comb begin
    w_allow         = '0;
    w_allow[NSTAGE] = out_ready;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      w_allow[i] = ~w_valid[i] | (stage_ready_go[i] & w_allow[i+1]);
    end
  end

  // Kill chain: a flush request at stage k kills every younger stage, never k itself.
  always_comb begin
    w_kill           = '0;
    w_kill[NSTAGE-1] = cancel_all;
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      w_kill[i] = w_kill[i+1] | flush_req[i+1];
    end
  end

  // A killed stage never hands off, so no doomed payload reaches the next stage.
  assign w_go      = w_valid & stage_ready_go & ~w_kill;
  assign w_go_in   = in_valid & ~(|flush_req) & ~cancel_all;
  assign w_go_prev = {w_go[NSTAGE-2:0], w_go_in};

  genvar g;
  generate
    for (g = 0; g < NSTAGE; g++) begin : g_stage
      if (g == 0) begin : g_first
        assign w_src[g] = in_payload;
      end else begin : g_rest
        assign w_src[g] = w_payload[g-1];
      end

      pipe_stage_reg #(
        .PAYLOAD_W (PAYLOAD_W)
      ) u_stage (
        .clk       (clk),
        .resetn    (resetn),
        .i_kill    (w_kill[g]),
        .i_allow   (w_allow[g]),
        .i_go_prev (w_go_prev[g]),
        .i_payload (w_src[g]),
        .o_valid   (w_valid[g]),
        .o_payload (w_payload[g])
      );

      assign stage_payload[stage_lsb(g, PAYLOAD_W) +: PAYLOAD_W] = w_payload[g];
    end
  endgenerate

  // Population count of the valid bits.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      w_occ = w_occ + OCC_W'(w_valid[i]);
    end
  end

  assign in_allow       = w_allow[0];
  assign out_valid      = w_valid[NSTAGE-1] & stage_ready_go[NSTAGE-1] & ~cancel_all;
  assign out_payload    = w_payload[NSTAGE-1];
  assign stage_valid    = w_valid;
  assign stage_allow_in = w_allow[NSTAGE-1:0];
  assign occupancy      = w_occ;

endmodule
